// File: rtl/fetch_redirect_unit.sv
// fetch_redirect_unit: instruction-fetch PC, IF/ID register and branch redirect/squash.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous active-high reset, overrides every other input
//   stall         hazard unit hold request for PC and IF/ID
//   switch_branch taken branch resolved in EX; redirects the PC and squashes IF/ID
//   branch_target EX-stage computed target (low two bits dropped on redirect)
//   instr_in      instruction memory read data for address pc_out
//   pc_out        current fetch address
//   if_id_pc      PC of the instruction held in ID
//   if_id_instr   instruction held in ID (NOP_INSTR when squashed)
//   if_id_valid   IF/ID holds a real instruction
//   flush_id_ex   squash ID/EX at the coming edge
//   misalign_err  sticky flag: some taken target had nonzero bits [1:0]
//   taken_count   saturating count of accepted redirects
module fetch_redirect_unit #(
    parameter int                     PC_WIDTH  = 64,
    parameter logic [PC_WIDTH-1:0]    RESET_PC  = '0,
    parameter logic [31:0]            NOP_INSTR = 32'h0000_0013,
    parameter int                     CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 switch_branch,
    input  logic [PC_WIDTH-1:0]  branch_target,
    input  logic [31:0]          instr_in,
    output logic [PC_WIDTH-1:0]  pc_out,
    output logic [PC_WIDTH-1:0]  if_id_pc,
    output logic [31:0]          if_id_instr,
    output logic                 if_id_valid,
    output logic                 flush_id_ex,
    output logic                 misalign_err,
    output logic [CNT_WIDTH-1:0] taken_count
);
    logic [PC_WIDTH-1:0]  pc_q, pc_d;
    logic [PC_WIDTH-1:0]  if_id_pc_q, if_id_pc_d;
    logic [31:0]          if_id_instr_q, if_id_instr_d;
    logic                 if_id_valid_q, if_id_valid_d;
    logic                 misalign_q, misalign_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [PC_WIDTH-1:0]  target_aligned;
    logic                 advance;

    assign target_aligned = {branch_target[PC_WIDTH-1:2], 2'b00};
    // A redirect always wins over stall: wrong-path work must be squashed.
    assign advance = ~switch_branch & ~stall;

    always_comb begin
        pc_d          = switch_branch ? target_aligned : (advance ? pc_q + PC_WIDTH'(4) : pc_q);
        if_id_pc_d    = switch_branch ? '0 : (advance ? pc_q : if_id_pc_q);
        if_id_instr_d = switch_branch ? NOP_INSTR : (advance ? instr_in : if_id_instr_q);
        if_id_valid_d = switch_branch ? 1'b0 : (advance ? 1'b1 : if_id_valid_q);
        misalign_d    = misalign_q | (switch_branch & (branch_target[1:0] != 2'b00));
        // Saturate at all-ones rather than wrapping back to zero.
        cnt_d         = (switch_branch && cnt_q != '1) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
            cnt_q         <= '0;
        end else begin
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
            misalign_q    <= misalign_d;
            cnt_q         <= cnt_d;
        end
    end

    assign pc_out       = pc_q;
    assign if_id_pc     = if_id_pc_q;
    assign if_id_instr  = if_id_instr_q;
    assign if_id_valid  = if_id_valid_q;
    assign misalign_err = misalign_q;
    assign taken_count  = cnt_q;
    // Combinational so ID/EX squashes at the same edge the PC is redirected.
    assign flush_id_ex  = switch_branch & ~reset;
endmodule

// File: tb/tb_fetch_redirect_unit.sv
// tb_fetch_redirect_unit: directed and randomized checks of fetch_redirect_unit against a spec-level model.
module tb_fetch_redirect_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        switch_branch = 1'b0;
    logic [63:0] branch_target = 64'h0;
    logic [31:0] instr_in = 32'h0;

    logic [63:0] pc_out, if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid, flush_id_ex, misalign_err;
    logic [15:0] taken_count;

    logic [63:0] c_pc, c_ipc;
    logic [31:0] c_instr;
    logic        c_valid, c_flush, c_err;
    logic [3:0]  c_cnt;

    logic [7:0]  w_pc, w_ipc;
    logic [31:0] w_instr;
    logic        w_valid, w_flush, w_err;
    logic [15:0] w_cnt;

    int passed = 0;
    int total = 0;

    // Reference model state: plain values derived from the behavioural rules.
    logic [63:0] m_pc, m_ipc;
    logic [31:0] m_instr;
    logic        m_valid, m_err;
    int          m_n;
    logic [7:0]  m_pcw;

    always #5 clk = ~clk;

    fetch_redirect_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .switch_branch(switch_branch),
        .branch_target(branch_target), .instr_in(instr_in), .pc_out(pc_out),
        .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
        .flush_id_ex(flush_id_ex), .misalign_err(misalign_err), .taken_count(taken_count)
    );

    fetch_redirect_unit #(.CNT_WIDTH(4)) dut_c (
        .clk(clk), .reset(reset), .stall(stall), .switch_branch(switch_branch),
        .branch_target(branch_target), .instr_in(instr_in), .pc_out(c_pc),
        .if_id_pc(c_ipc), .if_id_instr(c_instr), .if_id_valid(c_valid),
        .flush_id_ex(c_flush), .misalign_err(c_err), .taken_count(c_cnt)
    );

    fetch_redirect_unit #(.PC_WIDTH(8), .RESET_PC(8'hFC)) dut_w (
        .clk(clk), .reset(reset), .stall(stall), .switch_branch(switch_branch),
        .branch_target(branch_target[7:0]), .instr_in(instr_in), .pc_out(w_pc),
        .if_id_pc(w_ipc), .if_id_instr(w_instr), .if_id_valid(w_valid),
        .flush_id_ex(w_flush), .misalign_err(w_err), .taken_count(w_cnt)
    );

    // Advance the model by one edge using the currently driven inputs, then let the DUT take the edge.
    task automatic tick();
        if (reset) begin
            m_pc = 64'h0; m_ipc = 64'h0; m_instr = NOP; m_valid = 1'b0;
            m_err = 1'b0; m_n = 0; m_pcw = 8'hFC;
        end else if (switch_branch) begin
            m_pc = branch_target - 64'(branch_target % 4);
            m_pcw = m_pc[7:0];
            m_ipc = 64'h0; m_instr = NOP; m_valid = 1'b0;
            m_err = m_err | (branch_target % 4 != 0);
            m_n = m_n + 1;
        end else if (!stall) begin
            m_ipc = m_pc; m_instr = instr_in; m_valid = 1'b1;
            m_pc = m_pc + 64'd4;
            m_pcw = m_pcw + 8'd4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; switch_branch = 1'b1; branch_target = 64'h40; stall = 1'b0;
        tick();
        tick();
        total++; if (pc_out !== 64'h0) $display("FAIL reset_pc got %h want 0", pc_out); else passed++;
        total++; if (if_id_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", if_id_valid); else passed++;
        total++; if (if_id_instr !== NOP) $display("FAIL reset_instr got %h want %h", if_id_instr, NOP); else passed++;
        total++; if (if_id_pc !== 64'h0) $display("FAIL reset_ifid_pc got %h want 0", if_id_pc); else passed++;
        total++; if (flush_id_ex !== 1'b0) $display("FAIL reset_flush got %b want 0", flush_id_ex); else passed++;
        total++; if (taken_count !== 16'h0) $display("FAIL reset_count got %0d want 0", taken_count); else passed++;
        total++; if (misalign_err !== 1'b0) $display("FAIL reset_err got %b want 0", misalign_err); else passed++;
        total++; if (w_pc !== 8'hFC) $display("FAIL reset_pc8 got %h want fc", w_pc); else passed++;
        switch_branch = 1'b0;
    endtask

    task automatic test_sequential();
        reset = 1'b0; instr_in = 32'hAAAA_0001;
        #1;
        total++; if (pc_out !== 64'h0) $display("FAIL seq_pc0 got %h want 0", pc_out); else passed++;
        tick();
        total++; if (pc_out !== 64'h4) $display("FAIL seq_pc1 got %h want 4", pc_out); else passed++;
        total++; if (if_id_pc !== 64'h0 || if_id_instr !== 32'hAAAA_0001 || if_id_valid !== 1'b1)
            $display("FAIL seq_ifid1 got pc=%h instr=%h v=%b want 0/aaaa0001/1", if_id_pc, if_id_instr, if_id_valid); else passed++;
        instr_in = 32'hAAAA_0002;
        tick();
        total++; if (pc_out !== 64'h8) $display("FAIL seq_pc2 got %h want 8", pc_out); else passed++;
        total++; if (if_id_pc !== 64'h4 || if_id_instr !== 32'hAAAA_0002 || if_id_valid !== 1'b1)
            $display("FAIL seq_ifid2 got pc=%h instr=%h v=%b want 4/aaaa0002/1", if_id_pc, if_id_instr, if_id_valid); else passed++;
    endtask

    task automatic test_branch();
        instr_in = 32'h1234_5678;
        tick();
        tick();
        total++; if (pc_out !== 64'h10) $display("FAIL br_pre_pc got %h want 10", pc_out); else passed++;
        switch_branch = 1'b1; branch_target = 64'h100;
        #1;
        total++; if (flush_id_ex !== 1'b1) $display("FAIL br_flush got %b want 1", flush_id_ex); else passed++;
        tick();
        switch_branch = 1'b0;
        total++; if (pc_out !== 64'h100) $display("FAIL br_pc got %h want 100", pc_out); else passed++;
        total++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP)
            $display("FAIL br_squash got v=%b instr=%h want 0/%h", if_id_valid, if_id_instr, NOP); else passed++;
        #1;
        total++; if (flush_id_ex !== 1'b0) $display("FAIL br_flush_off got %b want 0", flush_id_ex); else passed++;
        instr_in = 32'hBEEF_0100;
        tick();
        total++; if (if_id_pc !== 64'h100 || if_id_valid !== 1'b1 || if_id_instr !== 32'hBEEF_0100)
            $display("FAIL br_target_ifid got pc=%h v=%b instr=%h want 100/1/beef0100", if_id_pc, if_id_valid, if_id_instr); else passed++;
        total++; if (taken_count !== 16'd1) $display("FAIL br_count got %0d want 1", taken_count); else passed++;
    endtask

    task automatic test_stall();
        logic [31:0] held;
        switch_branch = 1'b1; branch_target = 64'h18;
        tick();
        switch_branch = 1'b0;
        tick();
        held = 32'hC0DE_001C; instr_in = held;
        tick();
        total++; if (pc_out !== 64'h20) $display("FAIL st_pre_pc got %h want 20", pc_out); else passed++;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr_in = $urandom;
            tick();
            total++; if (pc_out !== 64'h20 || if_id_pc !== 64'h1C || if_id_instr !== held || if_id_valid !== 1'b1)
                $display("FAIL st_hold%0d got pc=%h ipc=%h instr=%h v=%b want 20/1c/%h/1", i, pc_out, if_id_pc, if_id_instr, if_id_valid, held); else passed++;
        end
        switch_branch = 1'b1; branch_target = 64'h200;
        tick();
        total++; if (pc_out !== 64'h200) $display("FAIL st_br_pc got %h want 200", pc_out); else passed++;
        total++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP || if_id_pc !== 64'h0)
            $display("FAIL st_br_squash got v=%b instr=%h ipc=%h want 0/%h/0", if_id_valid, if_id_instr, if_id_pc, NOP); else passed++;
        total++; if (taken_count !== 16'd3) $display("FAIL st_count got %0d want 3", taken_count); else passed++;
        switch_branch = 1'b0; stall = 1'b0;
    endtask

    task automatic test_back_to_back();
        reset = 1'b1;
        tick();
        reset = 1'b0; switch_branch = 1'b1; branch_target = 64'h302;
        tick();
        total++; if (pc_out !== 64'h300) $display("FAIL b2b_pc1 got %h want 300", pc_out); else passed++;
        total++; if (misalign_err !== 1'b1) $display("FAIL b2b_err got %b want 1", misalign_err); else passed++;
        branch_target = 64'h400;
        tick();
        total++; if (pc_out !== 64'h400) $display("FAIL b2b_pc2 got %h want 400", pc_out); else passed++;
        switch_branch = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        total++; if (misalign_err !== 1'b1) $display("FAIL b2b_err_sticky got %b want 1", misalign_err); else passed++;
        total++; if (taken_count !== 16'd2) $display("FAIL b2b_count got %0d want 2", taken_count); else passed++;
    endtask

    task automatic test_saturation_wrap();
        reset = 1'b1;
        tick();
        reset = 1'b0; switch_branch = 1'b1;
        for (int i = 0; i < 20; i++) begin
            branch_target = 64'(i * 16);
            tick();
        end
        switch_branch = 1'b0;
        total++; if (c_cnt !== 4'd15) $display("FAIL sat_count4 got %0d want 15", c_cnt); else passed++;
        total++; if (taken_count !== 16'd20) $display("FAIL sat_count16 got %0d want 20", taken_count); else passed++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (w_pc !== 8'hFC) $display("FAIL wrap_pre got %h want fc", w_pc); else passed++;
        tick();
        total++; if (w_pc !== 8'h00) $display("FAIL wrap_pc got %h want 00", w_pc); else passed++;
        total++; if (w_ipc !== 8'hFC || w_valid !== 1'b1) $display("FAIL wrap_ifid got ipc=%h v=%b want fc/1", w_ipc, w_valid); else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            stall = ($urandom_range(0, 9) < 3);
            switch_branch = ($urandom_range(0, 9) < 2);
            branch_target = {$urandom, $urandom};
            instr_in = $urandom;
            #1;
            total++; if (flush_id_ex !== (switch_branch & ~reset))
                $display("FAIL rnd_flush[%0d] got %b want %b", i, flush_id_ex, switch_branch & ~reset); else passed++;
            tick();
            total++; if (pc_out !== m_pc || if_id_pc !== m_ipc || if_id_instr !== m_instr || if_id_valid !== m_valid)
                $display("FAIL rnd_pipe[%0d] got pc=%h ipc=%h instr=%h v=%b want %h/%h/%h/%b", i, pc_out, if_id_pc, if_id_instr, if_id_valid, m_pc, m_ipc, m_instr, m_valid); else passed++;
            total++; if (misalign_err !== m_err) $display("FAIL rnd_err[%0d] got %b want %b", i, misalign_err, m_err); else passed++;
            total++; if (taken_count !== 16'(m_n > 65535 ? 65535 : m_n))
                $display("FAIL rnd_count[%0d] got %0d want %0d", i, taken_count, m_n); else passed++;
            total++; if (c_cnt !== 4'(m_n > 15 ? 15 : m_n)) $display("FAIL rnd_count4[%0d] got %0d want %0d", i, c_cnt, m_n > 15 ? 15 : m_n); else passed++;
            total++; if (w_pc !== m_pcw) $display("FAIL rnd_pc8[%0d] got %h want %h", i, w_pc, m_pcw); else passed++;
        end
        reset = 1'b0; stall = 1'b0; switch_branch = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_back_to_back();
        test_saturation_wrap();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
- Instruction-fetch stage with program counter, IF/ID pipeline register and branch-redirect/flush logic.
- Sits directly downstream of the branch control block: consumes switch_branch plus the EX-stage branch target, redirects the PC, and squashes wrong-path instructions.
- Also honours the hazard-unit stall and keeps a saturating count of taken redirects for debug.

Parameters:
- PC_WIDTH, 64, width of PC and branch target.
- RESET_PC, 0, PC value after reset.
- NOP_INSTR, 32'h00000013, instruction word inserted on squash (addi x0,x0,0).
- CNT_WIDTH, 16, width of taken-redirect counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard unit: hold PC and IF/ID.
- switch_branch  input  1  branch taken, resolved in EX.
- branch_target  input  PC_WIDTH  EX-stage computed target.
- instr_in  input  32  instruction memory read data for address pc_out (combinational read).
- pc_out  output  PC_WIDTH  current fetch address.
- if_id_pc  output  PC_WIDTH  registered PC of the instruction in ID.
- if_id_instr  output  32  registered instruction in ID.
- if_id_valid  output  1  IF/ID holds a real instruction.
- flush_id_ex  output  1  squash ID/EX at the coming edge.
- misalign_err  output  1  sticky: a taken target had bits [1:0] != 0.
- taken_count  output  CNT_WIDTH  saturating count of accepted redirects.

Behaviour:
- Reset is synchronous and active-high on clk and overrides all other inputs:
  - pc_out=RESET_PC, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0.
  - misalign_err=0, taken_count=0.
  - flush_id_ex=0 while reset is high.
- Priority per edge: reset > switch_branch > stall > normal advance.
- REDIRECT (switch_branch=1, reset=0):
  - pc_out <= {branch_target[PC_WIDTH-1:2],2'b00}.
  - if_id_instr <= NOP_INSTR, if_id_valid <= 0, if_id_pc <= 0.
  - taken_count <= taken_count+1, saturating at all-ones; it never wraps to 0.
  - If branch_target[1:0]!=0, misalign_err <= 1. It stays set until reset.
  - Stall is ignored in the redirect cycle, because wrong-path work must be squashed.
- flush_id_ex = switch_branch & ~reset, combinational, same cycle as switch_branch, so that ID/EX squashes at the same edge.
- STALL (stall=1, switch_branch=0): pc_out, if_id_pc, if_id_instr and if_id_valid hold their values; taken_count holds.
- ADVANCE (stall=0, switch_branch=0):
  - pc_out <= pc_out+4, modulo 2^PC_WIDTH (wraps from all-ones-minus-3 to 0).
  - if_id_pc <= pc_out, if_id_instr <= instr_in, if_id_valid <= 1.
- Latency:
  - Redirect target appears on pc_out one edge after switch_branch is sampled high.
  - The first target instruction reaches IF/ID one edge after that, provided there is no stall.
- Back-to-back redirects: each cycle with switch_branch=1 reloads the PC from that cycle's target and increments the counter. The second redirect wins.
- switch_branch=1 together with reset=1: reset wins, the counter stays 0 and flush_id_ex=0.
- The block contains no other state; all outputs are driven directly from registers, except flush_id_ex.

Test Plan:
- Reset: hold reset 2 cycles with switch_branch=1 and target=0x40 -> pc_out=0, if_id_valid=0, if_id_instr=0x00000013, flush_id_ex=0, taken_count=0.
- Sequential fetch: release reset, instr_in=0xAAAA0001 then 0xAAAA0002 -> pc_out 0,4,8; if_id_pc=0/instr=0xAAAA0001, then if_id_pc=4/instr=0xAAAA0002, valid=1.
- Taken branch: at pc_out=0x10 pulse switch_branch with target=0x100 -> flush_id_ex=1 that cycle; next cycle pc_out=0x100, if_id_valid=0, instr=NOP; following cycle if_id_pc=0x100, valid=1; taken_count=1.
- Stall vs branch: stall=1 for 3 cycles at pc_out=0x20 -> pc_out and IF/ID unchanged. Then stall=1 and switch_branch=1 with target=0x200 -> pc_out=0x200 and IF/ID squashed.
- Misaligned and back-to-back: targets 0x302 then 0x400 on consecutive cycles -> pc_out=0x300 then 0x400, misalign_err=1 and still 1 after 10 more cycles, taken_count=2.
- Saturation and wrap: run with CNT_WIDTH=4 and 20 redirects -> taken_count=15. Run with PC_WIDTH=8 and RESET_PC=0xFC, then advance -> pc_out=0x00.
